// File: rtl/pca_pkg.sv
// Shared PCA definitions: Givens writer FSM states, default dimensions and
// the saturating negate used by the rotation datapath.
package pca_pkg;

  localparam int PCA_N      = 4;
  localparam int PCA_DATA_W = 8;
  localparam int PCA_FRAC_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } givens_wr_state_t;

  // Negate a w-bit value carried sign-extended in 32 bits; the most negative
  // w-bit value has no positive counterpart and clamps to the most positive.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    return (x == most_neg) ? ~most_neg : -x;
  endfunction

endpackage

// File: rtl/givens_matrix_writer_if.sv
// Request/completion handshake plus Givens BRAM port A, bundled for the writer.
interface givens_matrix_writer_if
  import pca_pkg::*;
#(
  parameter int N      = PCA_N,
  parameter int DATA_W = PCA_DATA_W,
  parameter int ADDR_W = $clog2(N)
) ();

  logic                     start;
  logic                     mode;
  logic [ADDR_W-1:0]        p;
  logic [ADDR_W-1:0]        q;
  logic signed [DATA_W-1:0] cos_data;
  logic signed [DATA_W-1:0] sin_data;
  logic                     busy;
  logic                     ena_givens;
  logic                     wea_givens;
  logic [ADDR_W-1:0]        addra_givens;
  logic [N*DATA_W-1:0]      dina_givens;
  logic                     done;
  logic                     err;

  modport master (
    input  start, mode, p, q, cos_data, sin_data,
    output busy, ena_givens, wea_givens, addra_givens, dina_givens, done, err
  );

  modport slave (
    output start, mode, p, q, cos_data, sin_data,
    input  busy, ena_givens, wea_givens, addra_givens, dina_givens, done, err
  );

endinterface

// File: rtl/givens_row_gen.sv
// Combinational generator for one row of the N x N Givens rotation matrix;
// column 0 lands in the most significant element of the word.
module givens_row_gen
  import pca_pkg::*;
#(
  parameter int N      = PCA_N,
  parameter int DATA_W = PCA_DATA_W,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic [ADDR_W-1:0]        row,
  input  logic [ADDR_W-1:0]        p,
  input  logic [ADDR_W-1:0]        q,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] s,
  input  logic signed [DATA_W-1:0] one,
  output logic [N*DATA_W-1:0]      word
);

  logic signed [DATA_W-1:0] neg_s;

  assign neg_s = DATA_W'(sat_neg(32'(s), DATA_W));

  always_comb begin
    word = '0;
    for (int j = 0; j < N; j++) begin
      logic signed [DATA_W-1:0] elem;
      elem = '0;
      if (row == p) begin
        if (int'(p) == j)      elem = c;
        else if (int'(q) == j) elem = s;
      end else if (row == q) begin
        if (int'(p) == j)      elem = neg_s;
        else if (int'(q) == j) elem = c;
      end else if (int'(row) == j) begin
        elem = one;
      end
      word[(N-1-j)*DATA_W +: DATA_W] = elem;
    end
  end

endmodule

// File: rtl/givens_matrix_writer.sv
// Latches a rotation request and streams the Givens matrix rows into the
// Givens BRAM, one row per clock, in full or sparse (rows p and q) mode.
module givens_matrix_writer
  import pca_pkg::*;
#(
  parameter int N      = PCA_N,
  parameter int DATA_W = PCA_DATA_W,
  parameter int FRAC_W = PCA_FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  givens_matrix_writer_if.master bus
);

  localparam int ADDR_W = $clog2(N);
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

  givens_wr_state_t state, state_nxt;

  logic [ADDR_W-1:0]        cnt;
  logic                     err_l;
  logic                     mode_l;
  logic [ADDR_W-1:0]        p_l, q_l;
  logic signed [DATA_W-1:0] cos_l, sin_l;

  logic [ADDR_W-1:0]   lo, hi, row;
  logic                last, bad;
  logic [N*DATA_W-1:0] row_word;

  logic                busy_r, ena_r, wea_r, done_r, err_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [N*DATA_W-1:0] din_r;
  logic                busy_d, ena_d, wea_d, done_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [N*DATA_W-1:0] din_d;

  // Request operands are captured once and never re-read during the run.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mode_l <= bus.mode;
      p_l    <= bus.p;
      q_l    <= bus.q;
      cos_l  <= bus.cos_data;
      sin_l  <= bus.sin_data;
    end
  end

  assign lo   = (p_l < q_l) ? p_l : q_l;
  assign hi   = (p_l < q_l) ? q_l : p_l;
  assign row  = mode_l ? ((cnt == '0) ? lo : hi) : cnt;
  assign last = mode_l ? (cnt == ADDR_W'(1)) : (cnt == ADDR_W'(N - 1));
  assign bad  = (p_l == q_l) || (int'(p_l) >= N) || (int'(q_l) >= N);

  givens_row_gen #(
    .N      (N),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_row_gen (
    .row  (row),
    .p    (p_l),
    .q    (q_l),
    .c    (cos_l),
    .s    (sin_l),
    .one  (ONE),
    .word (row_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_l <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CHECK) begin
        cnt   <= '0;
        err_l <= bad;
      end else if (state == WRITE) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = bad ? DONE : WRITE;
      WRITE:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are the registered image of the current state, one cycle later.
  always_comb begin
    busy_d = (state == CHECK) || (state == WRITE);
    ena_d  = (state == WRITE);
    wea_d  = (state == WRITE);
    addr_d = addr_r;
    din_d  = din_r;
    done_d = (state == DONE);
    err_d  = (state == DONE) && err_l;
    if (state == WRITE) begin
      addr_d = row;
      din_d  = row_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      ena_r  <= 1'b0;
      wea_r  <= 1'b0;
      addr_r <= '0;
      din_r  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_d;
      ena_r  <= ena_d;
      wea_r  <= wea_d;
      addr_r <= addr_d;
      din_r  <= din_d;
      done_r <= done_d;
      err_r  <= err_d;
    end
  end

  assign bus.busy         = busy_r;
  assign bus.ena_givens   = ena_r;
  assign bus.wea_givens   = wea_r;
  assign bus.addra_givens = addr_r;
  assign bus.dina_givens  = din_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_givens_matrix_writer.sv
// Directed bench for givens_matrix_writer (N=4, DATA_W=8, FRAC_W=6).
module tb_givens_matrix_writer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  givens_matrix_writer_if #(.N(4), .DATA_W(8)) bus ();

  givens_matrix_writer #(.N(4), .DATA_W(8), .FRAC_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic m, input logic [1:0] pp, input logic [1:0] qq,
                        input logic [7:0] cc, input logic [7:0] ss, input logic hold);
    bus.mode     = m;
    bus.p        = pp;
    bus.q        = qq;
    bus.cos_data = cc;
    bus.sin_data = ss;
    bus.start    = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic expect_check(input string tag);
    step();
    chk_bit({tag, ".busy"}, bus.busy, 1'b1);
    chk_bit({tag, ".ena_chk"}, bus.ena_givens, 1'b0);
  endtask

  task automatic expect_write(input string tag, input logic [1:0] a, input logic [31:0] d);
    step();
    chk_bit({tag, ".ena"}, bus.ena_givens, 1'b1);
    chk_bit({tag, ".wea"}, bus.wea_givens, 1'b1);
    chk_word({tag, ".addr"}, 32'(bus.addra_givens), 32'(a));
    chk_word({tag, ".din"}, bus.dina_givens, d);
  endtask

  task automatic expect_done(input string tag, input logic e);
    step();
    chk_bit({tag, ".done"}, bus.done, 1'b1);
    chk_bit({tag, ".err"}, bus.err, e);
    chk_bit({tag, ".busy_done"}, bus.busy, 1'b0);
    chk_bit({tag, ".ena_done"}, bus.ena_givens, 1'b0);
    chk_bit({tag, ".wea_done"}, bus.wea_givens, 1'b0);
  endtask

  task automatic expect_all_zero(input string tag);
    chk_bit({tag, ".busy"}, bus.busy, 1'b0);
    chk_bit({tag, ".ena"}, bus.ena_givens, 1'b0);
    chk_bit({tag, ".wea"}, bus.wea_givens, 1'b0);
    chk_word({tag, ".addr"}, 32'(bus.addra_givens), 32'h0);
    chk_word({tag, ".din"}, bus.dina_givens, 32'h0);
    chk_bit({tag, ".done"}, bus.done, 1'b0);
    chk_bit({tag, ".err"}, bus.err, 1'b0);
  endtask

  initial begin
    logic seen_done;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.p        = '0;
    bus.q        = '0;
    bus.cos_data = '0;
    bus.sin_data = '0;
    #2 rst = 1'b1;
    step();
    step();
    expect_all_zero("reset");
    rst = 1'b0;
    step();

    // Full mode, p=0 q=2, c=s=0x2D
    launch(1'b0, 2'd0, 2'd2, 8'h2D, 8'h2D, 1'b0);
    expect_check("full");
    expect_write("full.r0", 2'd0, 32'h2D002D00);
    expect_write("full.r1", 2'd1, 32'h00400000);
    expect_write("full.r2", 2'd2, 32'hD3002D00);
    expect_write("full.r3", 2'd3, 32'h00000040);
    expect_done("full", 1'b0);
    chk_word("full.addr_hold", 32'(bus.addra_givens), 32'd3);
    chk_word("full.din_hold", bus.dina_givens, 32'h00000040);
    step();
    chk_bit("full.done_pulse", bus.done, 1'b0);

    // Sparse mode, p=3 q=1, c=0x40 s=0
    launch(1'b1, 2'd3, 2'd1, 8'h40, 8'h00, 1'b0);
    expect_check("sparse");
    expect_write("sparse.r1", 2'd1, 32'h00400000);
    expect_write("sparse.r3", 2'd3, 32'h00000040);
    expect_done("sparse", 1'b0);

    // Saturated negation of 0x80
    launch(1'b1, 2'd1, 2'd2, 8'h20, 8'h80, 1'b0);
    expect_check("sat");
    expect_write("sat.r1", 2'd1, 32'h00208000);
    expect_write("sat.r2", 2'd2, 32'h007F2000);
    expect_done("sat", 1'b0);

    // p == q rejected, then an immediate valid request
    launch(1'b0, 2'd2, 2'd2, 8'h40, 8'h10, 1'b0);
    expect_check("rej");
    expect_done("rej", 1'b1);
    launch(1'b1, 2'd0, 2'd1, 8'h40, 8'h10, 1'b0);
    expect_check("after_rej");
    expect_write("after_rej.r0", 2'd0, 32'h40100000);
    expect_write("after_rej.r1", 2'd1, 32'hF0400000);
    expect_done("after_rej", 1'b0);

    // Reset at the second write of a full run
    launch(1'b0, 2'd1, 2'd3, 8'h30, 8'h20, 1'b0);
    expect_check("rstmid");
    expect_write("rstmid.r0", 2'd0, 32'h40000000);
    expect_write("rstmid.r1", 2'd1, 32'h00300020);
    rst = 1'b1;
    #1;
    expect_all_zero("rstmid.clear");
    step();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_done = seen_done | bus.done;
    end
    chk_bit("rstmid.no_done", seen_done, 1'b0);
    chk_bit("rstmid.idle_busy", bus.busy, 1'b0);
    launch(1'b0, 2'd1, 2'd3, 8'h30, 8'h20, 1'b0);
    expect_check("rerun");
    expect_write("rerun.r0", 2'd0, 32'h40000000);
    expect_write("rerun.r1", 2'd1, 32'h00300020);
    expect_write("rerun.r2", 2'd2, 32'h00004000);
    expect_write("rerun.r3", 2'd3, 32'h00E00030);
    expect_done("rerun", 1'b0);

    // start held high; inputs change after the latch
    launch(1'b0, 2'd0, 2'd1, 8'h2D, 8'h2D, 1'b1);
    bus.mode     = 1'b1;
    bus.p        = 2'd2;
    bus.q        = 2'd3;
    bus.cos_data = 8'h11;
    bus.sin_data = 8'h22;
    expect_check("hold");
    expect_write("hold.r0", 2'd0, 32'h2D2D0000);
    expect_write("hold.r1", 2'd1, 32'hD32D0000);
    expect_write("hold.r2", 2'd2, 32'h00004000);
    expect_write("hold.r3", 2'd3, 32'h00000040);
    expect_done("hold", 1'b0);
    step();
    chk_bit("hold.edge7_busy", bus.busy, 1'b0);
    chk_bit("hold.edge7_done", bus.done, 1'b0);
    bus.start = 1'b0;
    expect_check("hold2");
    expect_write("hold2.r2", 2'd2, 32'h00001122);
    expect_write("hold2.r3", 2'd3, 32'h0000DE11);
    expect_done("hold2", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
